// File: rtl/fp_dot_seq.sv
`default_nettype none
// ============================================================================
// Module   : fp_dot_seq
// Purpose  : Drives a combinational FP MAC to accumulate a streamed dot product.
// Revision : 1.0  initial release
// ============================================================================
module fp_dot_seq #(
    parameter int SIG_WIDTH = 23,
    parameter int EXP_WIDTH = 8,
    parameter int LEN_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [LEN_WIDTH-1:0]           len,
    input  logic [2:0]                     rnd,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [SIG_WIDTH+EXP_WIDTH:0]   in_a,
    input  logic [SIG_WIDTH+EXP_WIDTH:0]   in_b,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [SIG_WIDTH+EXP_WIDTH:0]   out_z,
    output logic [7:0]                     out_status,
    output logic                           busy,
    output logic [SIG_WIDTH+EXP_WIDTH:0]   mac_a,
    output logic [SIG_WIDTH+EXP_WIDTH:0]   mac_b,
    output logic [SIG_WIDTH+EXP_WIDTH:0]   mac_c,
    output logic [2:0]                     mac_rnd,
    input  logic [SIG_WIDTH+EXP_WIDTH:0]   mac_z,
    input  logic [7:0]                     mac_status
);

    localparam logic [1:0]           c_IDLE  = 2'd0;
    localparam logic [1:0]           c_ACCUM = 2'd1;
    localparam logic [1:0]           c_DONE  = 2'd2;
    localparam logic [LEN_WIDTH-1:0] c_ONE   = LEN_WIDTH'(1);

    logic [1:0]                   r_state;
    logic [SIG_WIDTH+EXP_WIDTH:0] r_acc;
    logic [7:0]                   r_stat;
    logic [LEN_WIDTH-1:0]         r_cnt;
    logic [LEN_WIDTH-1:0]         r_len;
    logic [2:0]                   r_rnd;
    logic                         r_in_ready;
    logic                         r_out_valid;
    logic                         r_busy;

    logic                         w_accept;
    logic                         w_last;

    // r_in_ready is high exactly in ACCUM, so it doubles as the state qualifier
    assign w_accept = r_in_ready & in_valid;
    assign w_last   = (r_cnt == (r_len - c_ONE));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_acc       <= '0;
            r_stat      <= '0;
            r_cnt       <= '0;
            r_len       <= '0;
            r_rnd       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_acc  <= '0;
                        r_stat <= '0;
                        r_busy <= 1'b1;
                        if (len != '0) begin
                            r_cnt      <= '0;
                            r_len      <= len;
                            r_rnd      <= rnd;
                            r_in_ready <= 1'b1;
                            r_state    <= c_ACCUM;
                        end else begin
                            r_out_valid <= 1'b1;
                            r_state     <= c_DONE;
                        end
                    end
                end
                c_ACCUM: begin
                    if (w_accept) begin
                        r_acc  <= mac_z;
                        // zero flag describes only the latest sum; the rest accumulate
                        r_stat <= {r_stat[7:1] | mac_status[7:1], mac_status[0]};
                        r_cnt  <= r_cnt + c_ONE;
                        if (w_last) begin
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_state     <= c_DONE;
                        end
                    end
                end
                c_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= c_IDLE;
                    end
                end
                default: begin
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= c_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_z      = r_acc;
    assign out_status = r_stat;
    assign busy       = r_busy;
    assign mac_a      = in_a;
    assign mac_b      = in_b;
    assign mac_c      = r_acc;
    assign mac_rnd    = r_rnd;

endmodule
`default_nettype wire

// File: tb/tb_fp_dot_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_dot_seq
// Purpose  : Randomized self-checking bench for fp_dot_seq with a behavioural MAC.
// Revision : 1.0  initial release
// ============================================================================
module tb_fp_dot_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  len = 8'd0;
    logic [2:0]  rnd = 3'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = 32'd0;
    logic [31:0] in_b = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_z;
    logic [7:0]  out_status;
    logic        busy;
    logic [31:0] mac_a, mac_b, mac_c;
    logic [2:0]  mac_rnd;
    logic [31:0] mac_z;
    logic [7:0]  mac_status;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] va [256];
    logic [31:0] vb [256];
    logic [31:0] obs_z;
    logic [7:0]  obs_s;

    always #5 clk = ~clk;

    fp_dot_seq #(.SIG_WIDTH(23), .EXP_WIDTH(8), .LEN_WIDTH(8)) u_dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .rnd(rnd),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z),
        .out_status(out_status), .busy(busy),
        .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c), .mac_rnd(mac_rnd),
        .mac_z(mac_z), .mac_status(mac_status)
    );

    function automatic longint fp_to_int(input logic [31:0] f);
        longint m;
        int     e;
        e = int'(f[30:23]);
        if (e == 0) return 0;
        m = longint'({1'b1, f[22:0]});
        if (e >= 150) m = m <<< (e - 150);
        else          m = m >>> (150 - e);
        return f[31] ? -m : m;
    endfunction

    function automatic logic [31:0] int_to_fp(input longint v);
        longint      mag;
        longint      sh;
        int          p;
        logic [7:0]  e;
        logic [22:0] mt;
        if (v == 0) return 32'h0;
        mag = (v < 0) ? -v : v;
        p = 0;
        for (int k = 0; k < 48; k++) if (mag[k]) p = k;
        sh = (p >= 23) ? (mag >>> (p - 23)) : (mag <<< (23 - p));
        e  = 8'(127 + p);
        mt = sh[22:0];
        return {(v < 0), e, mt};
    endfunction

    // Integer-exact MAC with IEEE special cases; bits 3/5 are operand-derived markers
    function automatic logic [39:0] mac_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c);
        bit         an, bn, cn, ai, bi, ci, az, bz;
        logic [7:0] st;
        longint     r;
        an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        cn = (c[30:23] == 8'hFF) && (c[22:0] != 0);
        ai = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        bi = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        ci = (c[30:23] == 8'hFF) && (c[22:0] == 0);
        az = (a[30:23] == 8'h00);
        bz = (b[30:23] == 8'h00);
        if (an || bn || cn || (ai && bz) || (bi && az)) return {8'h04, 32'h7FC00000};
        if (ai || bi) begin
            if (ci && (c[31] != (a[31] ^ b[31]))) return {8'h04, 32'h7FC00000};
            return {8'h02, a[31] ^ b[31], 8'hFF, 23'h0};
        end
        if (ci) return {8'h02, c};
        r = fp_to_int(a) * fp_to_int(b) + fp_to_int(c);
        st    = 8'h00;
        st[0] = (r == 0);
        st[3] = a[21] & b[21];
        st[5] = a[22] & b[22];
        return {st, int_to_fp(r)};
    endfunction

    always_comb {mac_status, mac_z} = mac_fn(mac_a, mac_b, mac_c);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] rand_fp();
        int v;
        v = int'($urandom_range(0, 30)) - 15;
        return int_to_fp(longint'(v));
    endfunction

    // Runs one command; expected sum is a fold of the MAC over the stored pairs
    task automatic run_vector(input int n, input bit gaps, input int stall,
                              input logic [2:0] r, input string tag);
        logic [31:0] part_z;
        logic [7:0]  part_s;
        logic [39:0] m;
        int          i;
        int          cyc;
        bit          acc;
        start = 1'b1; len = n[7:0]; rnd = r;
        @(posedge clk); #1;
        start = 1'b0; len = 8'($urandom); rnd = 3'($urandom);
        check({tag, " busy"}, 32'(busy), 32'd1);
        part_z = 32'h0; part_s = 8'h0; i = 0; cyc = 0;
        while (i < n && cyc < 2000) begin
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_a  = va[i];
            in_b  = vb[i];
            start = 1'($urandom_range(0, 1));
            len   = 8'($urandom);
            acc   = in_valid && in_ready;
            if (acc) check({tag, " mac_c"}, mac_c, part_z);
            if (acc && i == 0) check({tag, " mac_rnd"}, 32'(mac_rnd), 32'(r));
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                m      = mac_fn(va[i], vb[i], part_z);
                part_z = m[31:0];
                part_s = {part_s[7:1] | m[39:33], m[32]};
                i++;
            end
        end
        in_valid = 1'b0;
        if (i < n) check({tag, " accept timeout"}, 32'(i), 32'(n));
        check({tag, " out_valid latency"}, 32'(out_valid), 32'd1);
        check({tag, " in_ready in DONE"}, 32'(in_ready), 32'd0);
        for (int k = 0; k < stall; k++) begin
            start = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            check({tag, " stalled out_z"}, out_z, part_z);
            check({tag, " stalled busy"}, 32'(busy), 32'd1);
        end
        obs_z = out_z;
        obs_s = out_status;
        check({tag, " out_z"}, out_z, part_z);
        check({tag, " out_status"}, 32'(out_status), 32'(part_s));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        start     = 1'b0;
        check({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
        check({tag, " busy drop"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset in_ready", 32'(in_ready), 32'd0);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_z", out_z, 32'd0);
        check("reset out_status", 32'(out_status), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset mac_c", mac_c, 32'd0);
        check("reset mac_rnd", 32'(mac_rnd), 32'd0);

        va[0] = 32'h3F800000; vb[0] = 32'h40000000;
        va[1] = 32'h40400000; vb[1] = 32'h40800000;
        run_vector(2, 1'b0, 0, 3'd0, "dot14");
        check("dot14 value", obs_z, 32'h41600000);
        check("dot14 status", 32'(obs_s), 32'h0);
        run_vector(2, 1'b1, 4, 3'd0, "dot14 stall");
        check("dot14 stall value", obs_z, 32'h41600000);

        run_vector(0, 1'b0, 1, 3'd5, "len0");
        check("len0 value", obs_z, 32'h0);
        check("len0 status", 32'(obs_s), 32'h0);

        va[0] = 32'h7F800000; vb[0] = 32'h00000000;
        va[1] = 32'h3F800000; vb[1] = 32'h3F800000;
        run_vector(2, 1'b0, 0, 3'd1, "inf0");
        check("inf0 invalid", 32'(obs_s[2]), 32'd1);
        check("inf0 nan exp", 32'(obs_z[30:23]), 32'hFF);

        // abort a len=4 vector after one accepted pair
        start = 1'b1; len = 8'd4; rnd = 3'd2;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1; in_a = 32'h41200000; in_b = 32'h41200000;
        @(posedge clk); #1;
        in_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        check("abort in_ready", 32'(in_ready), 32'd0);
        check("abort mac_c", mac_c, 32'd0);
        va[0] = 32'h40000000; vb[0] = 32'h40000000;
        run_vector(1, 1'b0, 0, 3'd0, "post abort");
        check("post abort value", obs_z, 32'h40800000);

        for (int t = 0; t < 20; t++) begin
            n = (t % 7 == 3) ? 0 : int'($urandom_range(1, 9));
            for (int j = 0; j < n; j++) begin
                va[j] = rand_fp();
                vb[j] = rand_fp();
            end
            run_vector(n, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                       3'($urandom), "rand");
        end

        for (int j = 0; j < 255; j++) begin
            va[j] = rand_fp();
            vb[j] = rand_fp();
        end
        run_vector(255, 1'b0, 1, 3'd3, "len255");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
